// File: rtl/bus_source_arbiter_pkg.sv
// Shared bus package: arbiter state encoding and default sizing.
package bus_source_arbiter_pkg;

  localparam int NUM_SRC_DEF = 24;
  localparam int SEL_W_DEF   = 5;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/bus_source_arbiter_rr_pick.sv
// rr_pick: rotate-priority pick of the next index after last_ptr.
module rr_pick
  import bus_source_arbiter_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int SEL_W   = SEL_W_DEF
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [SEL_W-1:0]   last_ptr_i,
  output logic               vld_o,
  output logic [SEL_W-1:0]   idx_o
);

  int         j;
  logic [SEL_W-1:0] cand;

  // Offset 1 first, offset NUM_SRC (last_ptr itself) last.
  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    j     = 0;
    cand  = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      j = int'(last_ptr_i) + i;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      cand = SEL_W'(j);
      if (!vld_o && req_i[cand]) begin
        vld_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/bus_source_arbiter.sv
// Round-robin bus source arbiter, one-cycle grants.
// Optional owner lock compiled in with BUS_ARB_LOCK_EN.
module bus_source_arbiter
  import bus_source_arbiter_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int SEL_W   = SEL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic               stall,
`ifdef BUS_ARB_LOCK_EN
  input  logic               lock,
`endif
  output logic [NUM_SRC-1:0] grant,
  output logic [SEL_W-1:0]   select,
  output logic               bus_valid
);

  arb_state_e         state_q;
  logic [NUM_SRC-1:0] grant_q;
  logic [SEL_W-1:0]   sel_q;
  logic               valid_q;
  logic [SEL_W-1:0]   last_q;

  logic               pick_vld;
  logic [SEL_W-1:0]   pick_idx;
  logic [NUM_SRC-1:0] onehot;
  logic               lock_hold;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_pick (
    .req_i      (req),
    .last_ptr_i (last_q),
    .vld_o      (pick_vld),
    .idx_o      (pick_idx)
  );

  always_comb begin
    onehot           = '0;
    onehot[pick_idx] = 1'b1;
  end

`ifdef BUS_ARB_LOCK_EN
  assign lock_hold = (state_q == OWN) && lock && req[sel_q];
`else
  assign lock_hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= SEL_W'(NUM_SRC - 1);
    end else if (!stall) begin
      unique case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q <= OWN;
            grant_q <= onehot;
            sel_q   <= pick_idx;
            valid_q <= 1'b1;
            last_q  <= pick_idx;
          end
        end
        OWN: begin
          if (lock_hold) begin
            state_q <= OWN;
          end else if (pick_vld) begin
            grant_q <= onehot;
            sel_q   <= pick_idx;
            valid_q <= 1'b1;
            last_q  <= pick_idx;
          end else begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign select    = sel_q;
  assign bus_valid = valid_q;

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Self-checking bench for bus_source_arbiter (NUM_SRC=24).
module tb_bus_source_arbiter;

  localparam int N = 24;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic         stall = 1'b0;
`ifdef BUS_ARB_LOCK_EN
  logic         lock = 1'b0;
`endif
  logic [N-1:0] grant;
  logic [W-1:0] select;
  logic         bus_valid;

  int errors = 0;
  int checks = 0;

  bus_source_arbiter #(.NUM_SRC(N), .SEL_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .stall     (stall),
`ifdef BUS_ARB_LOCK_EN
    .lock      (lock),
`endif
    .grant     (grant),
    .select    (select),
    .bus_valid (bus_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] req;
    logic         stall;
    logic         vld;
    logic [W-1:0] sel;
  } vec_t;

  typedef struct {
    logic         vld;
    logic [W-1:0] sel;
    string        name;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[20];

  function automatic logic [N-1:0] oh(input logic v, input logic [W-1:0] s);
    logic [N-1:0] r;
    r = '0;
    if (v) r[s] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cmp_out(input exp_t e);
    chk({e.name, ".valid"}, 32'(bus_valid), 32'(e.vld));
    chk({e.name, ".select"}, 32'(select), 32'(e.sel));
    chk({e.name, ".grant"}, 32'(grant), 32'(oh(e.vld, e.sel)));
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic s,
                     input logic v, input logic [W-1:0] sl,
                     input string nm);
    exp_t e;
    req   = r;
    stall = s;
    e.vld = v;
    e.sel = sl;
    e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      cmp_out(e);
    end
  endtask

  initial begin
    tbl[0]  = '{24'h000001, 1'b0, 1'b1, 5'd0};
    tbl[1]  = '{24'h800001, 1'b0, 1'b1, 5'd23};
    tbl[2]  = '{24'h800001, 1'b0, 1'b1, 5'd0};
    tbl[3]  = '{24'h800001, 1'b0, 1'b1, 5'd23};
    tbl[4]  = '{24'h800001, 1'b0, 1'b1, 5'd0};
    tbl[5]  = '{24'h000000, 1'b0, 1'b0, 5'd0};
    tbl[6]  = '{24'h800001, 1'b0, 1'b1, 5'd23};
    tbl[7]  = '{24'h000020, 1'b0, 1'b1, 5'd5};
    tbl[8]  = '{24'h000100, 1'b1, 1'b1, 5'd5};
    tbl[9]  = '{24'h000100, 1'b1, 1'b1, 5'd5};
    tbl[10] = '{24'h000100, 1'b1, 1'b1, 5'd5};
    tbl[11] = '{24'h000100, 1'b0, 1'b1, 5'd8};
    tbl[12] = '{24'h000000, 1'b1, 1'b1, 5'd8};
    tbl[13] = '{24'h000000, 1'b0, 1'b0, 5'd0};
    tbl[14] = '{24'hFFFFFF, 1'b1, 1'b0, 5'd0};
    tbl[15] = '{24'hFFFFFF, 1'b0, 1'b1, 5'd9};
    tbl[16] = '{24'hFFFFFF, 1'b0, 1'b1, 5'd10};
    tbl[17] = '{24'h000200, 1'b0, 1'b1, 5'd9};
    tbl[18] = '{24'h000200, 1'b0, 1'b1, 5'd9};
    tbl[19] = '{24'h020000, 1'b0, 1'b1, 5'd17};

    #2;
    chk("rst.valid", 32'(bus_valid), 32'd0);
    chk("rst.grant", 32'(grant), 32'd0);
    chk("rst.select", 32'(select), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++)
      cyc(tbl[i].req, tbl[i].stall, tbl[i].vld, tbl[i].sel,
          $sformatf("vec%0d", i));

    // asynchronous reset while source 17 owns the bus
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.valid", 32'(bus_valid), 32'd0);
    chk("arst.grant", 32'(grant), 32'd0);
    chk("arst.select", 32'(select), 32'd0);
    req = 24'h020001;
    @(posedge clk);
    #1;
    chk("arst.hold", 32'(bus_valid), 32'd0);
    rst_n = 1'b1;
    cyc(24'h020001, 1'b0, 1'b1, 5'd0, "post_rst0");
    cyc(24'h020001, 1'b0, 1'b1, 5'd17, "post_rst1");

`ifdef BUS_ARB_LOCK_EN
    cyc(24'h000008, 1'b0, 1'b1, 5'd3, "lock_own");
    lock = 1'b1;
    for (int k = 0; k < 4; k++)
      cyc(24'h00FFFF, 1'b0, 1'b1, 5'd3, $sformatf("lock%0d", k));
    lock = 1'b0;
    cyc(24'h00FFFF, 1'b0, 1'b1, 5'd4, "lock_rel");
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
